// File: rtl/conv_weight_sched.sv
// conv_weight_sched: streams per-channel kernels from ROM into the conv stage and issues vsync/reuse pulses
module conv_weight_sched #(
  parameter int WIDTH_W  = 20,
  parameter int LEN      = 7,
  parameter int N_OC     = 64,
  parameter int WIDTH_A  = 12,
  parameter int WIDTH_CH = 6
) (
  input  logic                   i_sclk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_pass_req,
  input  logic                   i_pass_done,
  output logic                   o_rom_en,
  output logic [WIDTH_A-1:0]     o_rom_addr,
  input  logic [3*WIDTH_W-1:0]   i_rom_data,
  output logic                   o_vsync,
  output logic                   o_weight_vld,
  output logic [3*WIDTH_W-1:0]   o_weight,
  output logic                   o_reuse,
  output logic [WIDTH_CH-1:0]    o_ch_idx,
  output logic                   o_busy,
  output logic                   o_done
);
  localparam int K  = LEN * LEN;
  localparam int JW = $clog2(K);
  typedef enum logic [2:0] {IDLE, CLR, LOAD, FLUSH, READY, DRAIN, DONE} state_t;
  state_t                 state_q;
  logic [JW-1:0]          j_q;
  logic                   flush_q;
  logic [WIDTH_CH-1:0]    ch_q;
  logic [WIDTH_A-1:0]     base_q;
  logic                   pa_q;
  logic                   rom_en_q;
  logic [WIDTH_A-1:0]     rom_addr_q;
  logic                   vsync_q;
  logic                   v1_q;
  logic                   vld_q;
  logic [3*WIDTH_W-1:0]   weight_q;
  logic                   reuse_q;
  logic [WIDTH_CH-1:0]    ch_idx_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pa_d;
  logic                   fire_d;
  // a same-cycle pass_done retires the running pass before the reuse decision
  always_comb begin
    pa_d   = pa_q & ~i_pass_done;
    fire_d = (state_q == READY) & i_pass_req & ~pa_d;
  end
  // frame sequencer with registered outputs and the two-stage weight pipeline
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      j_q        <= '0;
      flush_q    <= 1'b0;
      ch_q       <= '0;
      base_q     <= '0;
      pa_q       <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      vsync_q    <= 1'b0;
      v1_q       <= 1'b0;
      vld_q      <= 1'b0;
      weight_q   <= '0;
      reuse_q    <= 1'b0;
      ch_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rom_en_q <= 1'b0;
      vsync_q  <= 1'b0;
      reuse_q  <= 1'b0;
      done_q   <= 1'b0;
      v1_q     <= rom_en_q;
      vld_q    <= v1_q;
      weight_q <= v1_q ? i_rom_data : '0;
      pa_q     <= pa_d | fire_d;
      case (state_q)
        IDLE: if (i_start) begin
          ch_q    <= '0;
          base_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= CLR;
        end
        CLR: begin
          vsync_q <= 1'b1;
          j_q     <= '0;
          state_q <= LOAD;
        end
        LOAD: begin
          rom_en_q   <= 1'b1;
          rom_addr_q <= base_q + WIDTH_A'(j_q);
          j_q        <= j_q + 1'b1;
          if (j_q == JW'(K - 1)) begin
            flush_q <= 1'b0;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) state_q <= READY;
        end
        READY: if (fire_d) begin
          reuse_q  <= 1'b1;
          ch_idx_q <= ch_q;
          j_q      <= '0;
          if (ch_q == WIDTH_CH'(N_OC - 1)) state_q <= DRAIN;
          else begin
            ch_q    <= ch_q + 1'b1;
            base_q  <= base_q + WIDTH_A'(K);
            state_q <= LOAD;
          end
        end
        DRAIN: if (i_pass_done) state_q <= DONE;
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_rom_en     = rom_en_q;
  assign o_rom_addr   = rom_addr_q;
  assign o_vsync      = vsync_q;
  assign o_weight_vld = vld_q;
  assign o_weight     = weight_q;
  assign o_reuse      = reuse_q;
  assign o_ch_idx     = ch_idx_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
endmodule

// File: tb/tb_conv_weight_sched.sv
// tb_conv_weight_sched: directed checks of the weight scheduler with LEN=3, N_OC=2
module tb_conv_weight_sched;
  logic        clk = 1'b0;
  logic        rst, start, req, pdone;
  logic        o_rom_en, o_vsync, o_weight_vld, o_reuse, o_busy, o_done;
  logic [11:0] o_rom_addr;
  logic [59:0] rom_q, o_weight;
  logic [5:0]  o_ch_idx;
  int n_vec = 0, n_err = 0, nvld = 0, nreuse = 0, nvs = 0;
  always #5 clk = ~clk;
  conv_weight_sched #(.WIDTH_W(20), .LEN(3), .N_OC(2), .WIDTH_A(12), .WIDTH_CH(6)) dut (
    .i_sclk(clk), .i_rst(rst), .i_start(start), .i_pass_req(req), .i_pass_done(pdone),
    .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_data(rom_q),
    .o_vsync(o_vsync), .o_weight_vld(o_weight_vld), .o_weight(o_weight),
    .o_reuse(o_reuse), .o_ch_idx(o_ch_idx), .o_busy(o_busy), .o_done(o_done)
  );
  function automatic logic [59:0] w(input int k);
    return {20'(k), 20'(k + 100), 20'(k + 200)};
  endfunction
  always_ff @(posedge clk) if (o_rom_en) rom_q <= w(int'(o_rom_addr));
  task automatic tick;
    @(posedge clk);
    #1;
    if (o_weight_vld) nvld++;
    if (o_reuse) nreuse++;
    if (o_vsync) nvs++;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 64'(o_rom_en), 64'(0));
    chk({tag, "_addr"}, 64'(o_rom_addr), 64'(0));
    chk({tag, "_vsync"}, 64'(o_vsync), 64'(0));
    chk({tag, "_vld"}, 64'(o_weight_vld), 64'(0));
    chk({tag, "_weight"}, 64'(o_weight), 64'(0));
    chk({tag, "_reuse"}, 64'(o_reuse), 64'(0));
    chk({tag, "_ch"}, 64'(o_ch_idx), 64'(0));
    chk({tag, "_busy"}, 64'(o_busy), 64'(0));
    chk({tag, "_done"}, 64'(o_done), 64'(0));
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; req = 1'b0; pdone = 1'b0;
    repeat (3) tick;
    chk_zero("reset");
    rst = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_clr", 64'(o_busy), 64'(1));
    chk("vsync_c1", 64'(o_vsync), 64'(0));
    tick;
    chk("vsync_c2", 64'(o_vsync), 64'(1));
    chk("en_c2", 64'(o_rom_en), 64'(0));
    for (int c = 3; c <= 13; c++) begin
      tick;
      start = (c == 6);
      chk("en_k0", 64'(o_rom_en), 64'(c <= 11));
      if (c <= 11) chk("addr_k0", 64'(o_rom_addr), 64'(c - 3));
      chk("vld_k0", 64'(o_weight_vld), 64'(c >= 5));
      if (c >= 5) chk("wt_k0", 64'(o_weight), 64'(w(c - 5)));
      chk("reuse_k0", 64'(o_reuse), 64'(0));
      chk("vsync_k0", 64'(o_vsync), 64'(0));
    end
    start = 1'b0;
    tick;
    pdone = 1'b1;
    chk("reuse_c14", 64'(o_reuse), 64'(0));
    tick;
    pdone = 1'b0;
    chk("reuse_idle_done", 64'(o_reuse), 64'(0));
    chk("ch_c15", 64'(o_ch_idx), 64'(0));
    tick;
    req = 1'b1;
    chk("en_c16", 64'(o_rom_en), 64'(0));
    tick;
    chk("reuse0", 64'(o_reuse), 64'(1));
    chk("reuse0_ch", 64'(o_ch_idx), 64'(0));
    chk("busy_c17", 64'(o_busy), 64'(1));
    for (int c = 18; c <= 28; c++) begin
      tick;
      chk("en_k1", 64'(o_rom_en), 64'(c <= 26));
      if (c <= 26) chk("addr_k1", 64'(o_rom_addr), 64'(c - 18 + 9));
      chk("vld_k1", 64'(o_weight_vld), 64'(c >= 20));
      if (c >= 20) chk("wt_k1", 64'(o_weight), 64'(w(c - 20 + 9)));
      chk("reuse_k1", 64'(o_reuse), 64'(0));
    end
    pdone = 1'b1;
    tick;
    pdone = 1'b0;
    req = 1'b0;
    chk("reuse1", 64'(o_reuse), 64'(1));
    chk("reuse1_ch", 64'(o_ch_idx), 64'(1));
    tick;
    chk("reuse_c30", 64'(o_reuse), 64'(0));
    chk("busy_drain", 64'(o_busy), 64'(1));
    tick;
    pdone = 1'b1;
    tick;
    pdone = 1'b0;
    chk("done_c32", 64'(o_done), 64'(0));
    chk("busy_c32", 64'(o_busy), 64'(1));
    tick;
    chk("done_c33", 64'(o_done), 64'(1));
    chk("busy_c33", 64'(o_busy), 64'(0));
    tick;
    chk("done_c34", 64'(o_done), 64'(0));
    chk("ch_hold", 64'(o_ch_idx), 64'(1));
    chk("tot_vld", 64'(nvld), 64'(18));
    chk("tot_reuse", 64'(nreuse), 64'(2));
    chk("tot_vsync", 64'(nvs), 64'(1));
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("vsync_f2", 64'(o_vsync), 64'(1));
    tick;
    chk("addr_f2_0", 64'(o_rom_addr), 64'(0));
    tick;
    tick;
    chk("addr_f2_2", 64'(o_rom_addr), 64'(2));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_zero("midrst");
    tick;
    start = 1'b1;
    chk("vld_flushed", 64'(o_weight_vld), 64'(0));
    chk("wt_flushed", 64'(o_weight), 64'(0));
    tick;
    start = 1'b0;
    chk("busy_restart", 64'(o_busy), 64'(1));
    tick;
    chk("vsync_restart", 64'(o_vsync), 64'(1));
    tick;
    chk("en_restart", 64'(o_rom_en), 64'(1));
    chk("addr_restart0", 64'(o_rom_addr), 64'(0));
    tick;
    chk("addr_restart1", 64'(o_rom_addr), 64'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
